bw_clk_gclk_div_nch: RTL
========================

Name: bw_clk_gclk_div_nch

Overview:
- Parametrised, multi-channel successor to the global-clock inverter cells. Produces NCH registered divided clocks with per-channel polarity select, plus one-cycle clock-enable pulses.
- Each channel's divide ratio is reprogrammed at runtime through a valid/ready port. A new ratio takes effect only at the channel's period boundary, so changes are glitch-free.
- Sits at the clock-tree header and feeds cluster clock gaters and slow-domain enables.

Parameters:
- NCH, 4, number of output channels (1..16).
- CW, 8, divide-ratio and counter width.
- DEF_DIV, 2, per-channel ratio loaded at reset (must be ≥2 and < 2^CW).

Ports:
- rclk  input  1  reference clock; all flops rise-edge.
- arst  input  1  asynchronous, active-high reset.
- en  input  NCH  per-channel run enable.
- inv  input  NCH  per-channel output polarity (1 = inverted).
- sync  input  1  realign all enabled channels to period start.
- cfg_vld  input  1  ratio update request.
- cfg_ch  input  CHW  target channel, where CHW = max(1, clog2(NCH)).
- cfg_div  input  CW  new divide ratio.
- cfg_rdy  output  1  combinational: target channel has no pending update.
- clkout  output  NCH  divided clock, flop output.
- ce  output  NCH  enable pulse in the last cycle of each period, flop output.

Behaviour:
- Reset (arst high, async):
  - cnt[i] = 0, div[i] = DEF_DIV, pend_v[i] = 0.
  - clkout = 0, ce = 0.
  - cfg_rdy therefore reads 1.
- Ratio D = div[i]. Any written value below 2 is clamped to 2.
- Counter: while en[i] = 1, cnt[i] counts 0..D-1 and wraps. Terminal count tc[i] is cnt[i] == D-1.
- Output decode: raw[i] = (cnt[i] < (D+1)/2), giving high = ceil(D/2) cycles and low = floor(D/2) cycles.
  - clkout[i] = raw[i] ^ inv[i].
  - ce[i] = tc[i] & en[i].
  - Both outputs are computed from next-state and registered, so they are aligned with cnt. There is no combinational path from any input to clkout or ce.
  - Consequence: a change on inv or en is visible one cycle later.
- Disabled channel (en[i] = 0):
  - cnt[i] held at 0, ce[i] = 0, clkout[i] = inv[i].
  - On en rising, the next cycle begins a period at cnt = 0, so raw goes high.
- Config handshake:
  - A transfer occurs when cfg_vld & cfg_rdy. It captures cfg_div into pend[cfg_ch] and sets pend_v.
  - cfg_vld while cfg_rdy = 0 is ignored; the requester must hold the request.
  - cfg_ch ≥ NCH is ignored, and cfg_rdy reads 1 for it.
- Applying a pending update:
  - If the channel is enabled, it applies on the cycle where tc[i] = 1 or sync = 1: div ← pend, pend_v ← 0, cnt ← 0.
  - If the channel is disabled, it applies on the cycle after capture.
  - A transfer in the same cycle as the channel's tc is not applied at that tc; it waits for the next boundary.
- sync:
  - Forces cnt ← 0 on every enabled channel and applies any pending update.
  - sync wins over normal counting; sync coinciding with tc behaves identically to tc.
- Reset mid-operation: all state returns to reset values immediately. Any in-flight pending update is discarded.

Decomposition:
- Package bw_clk_div_pkg holds:
  - clamp function (minimum ratio 2);
  - high-phase function (D+1)/2;
  - CHW derivation.
- Natural sub-module: bw_clk_div_chan, a single channel containing counter, div/pend registers, decode and output flops. It is instantiated NCH times by a generate loop.
- The top level holds only cfg decode, the cfg_rdy mux and sync fan-out.

Test Plan:
- Reset, then en = 4'b0001, inv = 0, DEF_DIV = 2 → clkout[0] toggles every cycle (period 2); ce[0] pulses every 2nd cycle; other clkout = 0.
- Write ch1 cfg_div = 5, then enable → clkout[1] high 3 / low 2; ce[1] pulses once per 5 cycles, in the cycle before cnt wraps.
- While ch1 runs D = 5 at cnt = 1, write cfg_div = 3:
  - cfg_rdy(ch1) drops the next cycle.
  - Period completes at 5, then switches to high 2 / low 1.
  - No runt pulse; cfg_rdy returns to 1.
- Write cfg_div = 0 → behaves as D = 2. Repeat with cfg_vld held while busy → second write accepted only after the first is applied.
- ch0 D = 4 and ch2 D = 6 running, assert sync 1 cycle at arbitrary phase → both at cnt = 0 next cycle; rising edges aligned; ce aligned every 12 cycles.
- Toggle inv[2] mid-run → clkout[2] inverts one cycle later with no counter disturbance. Assert arst mid-period → clkout/ce = 0 immediately, div back to 2, pending discarded.

Source files
------------

// File: rtl/bw_clk_div_pkg.sv
// bw_clk_div_pkg: shared helpers for the multi-channel divided-clock generator
package bw_clk_div_pkg;
  localparam int unsigned MIN_DIV = 2;
  function automatic int unsigned clamp_div(input int unsigned d);
    return d < MIN_DIV ? MIN_DIV : d;
  endfunction
  function automatic int unsigned hi_len(input int unsigned d);
    return (d + 1) / 2;
  endfunction
  function automatic int chw_of(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bw_clk_div_chan.sv
// bw_clk_div_chan: one divider channel with boundary-applied ratio updates
module bw_clk_div_chan
  import bw_clk_div_pkg::*;
#(
  parameter int CW      = 8,
  parameter int DEF_DIV = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_inv,
  input  logic          i_sync,
  input  logic          i_we,
  input  logic [CW-1:0] i_div,
  output logic          o_rdy,
  output logic          o_clk,
  output logic          o_ce
);
  logic [CW-1:0] r_cnt, r_div, r_pend;
  logic          r_pv, r_act, r_clk, r_ce;
  logic          w_tc, w_apply, w_wrap, w_raw;
  logic [CW-1:0] w_cnt_n, w_div_n;
  // r_act lets the first enabled cycle start a fresh period at cnt 0
  always_comb begin
    w_tc    = r_cnt == r_div - CW'(1);
    w_apply = r_pv & (~i_en | w_tc | i_sync);
    w_wrap  = ~i_en | ~r_act | w_tc | i_sync;
    w_cnt_n = w_wrap ? '0 : r_cnt + CW'(1);
    w_div_n = w_apply ? r_pend : r_div;
    w_raw   = 32'(w_cnt_n) < hi_len(32'(w_div_n));
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_div  <= CW'(DEF_DIV);
      r_pend <= CW'(DEF_DIV);
      r_pv   <= 1'b0;
      r_act  <= 1'b0;
      r_clk  <= 1'b0;
      r_ce   <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_n;
      r_div  <= w_div_n;
      r_act  <= i_en;
      r_pv   <= i_we | (r_pv & ~w_apply);
      r_pend <= i_we ? CW'(clamp_div(32'(i_div))) : r_pend;
      r_clk  <= i_en ? w_raw ^ i_inv : i_inv;
      r_ce   <= i_en & (w_cnt_n == w_div_n - CW'(1));
    end
  end
  assign o_rdy = ~r_pv;
  assign o_clk = r_clk;
  assign o_ce  = r_ce;
endmodule

// File: rtl/bw_clk_gclk_div_nch.sv
// bw_clk_gclk_div_nch: NCH registered divided clocks with runtime ratio config
module bw_clk_gclk_div_nch
  import bw_clk_div_pkg::*;
#(
  parameter  int NCH     = 4,
  parameter  int CW      = 8,
  parameter  int DEF_DIV = 2,
  localparam int CHW     = chw_of(NCH)
) (
  input  logic           rclk,
  input  logic           arst,
  input  logic [NCH-1:0] en,
  input  logic [NCH-1:0] inv,
  input  logic           sync,
  input  logic           cfg_vld,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_div,
  output logic           cfg_rdy,
  output logic [NCH-1:0] clkout,
  output logic [NCH-1:0] ce
);
  // unused channel codes read as always ready so the requester never stalls
  logic [2**CHW-1:0] w_rdy;
  assign cfg_rdy = w_rdy[cfg_ch];
  for (genvar i = 0; i < 2**CHW; i++) begin : g_ch
    if (i < NCH) begin : g_on
      bw_clk_div_chan #(.CW(CW), .DEF_DIV(DEF_DIV)) u_chan (
        .i_clk (rclk),
        .i_rst (arst),
        .i_en  (en[i]),
        .i_inv (inv[i]),
        .i_sync(sync),
        .i_we  (cfg_vld & cfg_rdy & (cfg_ch == CHW'(i))),
        .i_div (cfg_div),
        .o_rdy (w_rdy[i]),
        .o_clk (clkout[i]),
        .o_ce  (ce[i])
      );
    end else begin : g_off
      assign w_rdy[i] = 1'b1;
    end
  end
endmodule
